// File: rtl/pipeline_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// A slot is one shadow-pipeline entry describing an in-flight destination.
package pipeline_pkg;

   localparam int unsigned ADDR_SIZE_DEFAULT = 5;
   localparam int unsigned BP_RA = 1;
   localparam int unsigned BP_RB = 0;

   typedef struct packed {
      logic                         valid;
      logic [ADDR_SIZE_DEFAULT-1:0] rd;
      logic                         we;
      logic                         ld;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

   // A slot only produces a value worth forwarding if it really writes a nonzero register.
   function automatic logic slot_writes(input slot_t s, input logic [ADDR_SIZE_DEFAULT-1:0] r);
      return s.valid && s.we && (s.rd != '0) && (s.rd == r);
   endfunction

endpackage

// File: rtl/operand_match.sv
// Per-operand bypass selection: youngest matching writer wins, and a load
// still in EX turns the match into a load-use hazard instead of a bypass.
module operand_match
   import pipeline_pkg::*;
(
   input  logic                         active,
   input  logic [ADDR_SIZE_DEFAULT-1:0] src,
   input  slot_t                        ex_slot,
   input  slot_t                        mem_slot,
   input  slot_t                        wb_slot,
   output logic                         ex_hit_c,
   output logic                         mem_hit_c,
   output logic                         wb_hit_c,
   output logic                         ld_hazard_c
);

   always_comb begin
      ex_hit_c    = 1'b0;
      mem_hit_c   = 1'b0;
      wb_hit_c    = 1'b0;
      ld_hazard_c = 1'b0;
      if (active) begin
         if (slot_writes(ex_slot, src)) begin
            if (ex_slot.ld) ld_hazard_c = 1'b1;
            else            ex_hit_c    = 1'b1;
         end else if (slot_writes(mem_slot, src)) begin
            mem_hit_c = 1'b1;
         end else if (slot_writes(wb_slot, src)) begin
            wb_hit_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard controller: shadows EX/MEM/WB destinations, drives the
// decode bypass selects and the one-cycle load-use stall, and counts stalls.
module hazard_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEFAULT,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 D_valid,
   input  logic [ADDR_SIZE-1:0] D_ra,
   input  logic [ADDR_SIZE-1:0] D_rb,
   input  logic                 D_use_ra,
   input  logic                 D_use_rb,
   input  logic [ADDR_SIZE-1:0] D_rd,
   input  logic                 D_we,
   input  logic                 D_ld,
   input  logic                 D_flush,
   output logic [1:0]           EX_D_bp,
   output logic [1:0]           MEM_D_bp,
   output logic [1:0]           WB_D_bp,
   output logic                 D_stall,
   output logic [CNT_W-1:0]     stall_cnt
);

   slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic ra_active, rb_active;
   logic ra_ex, ra_mem, ra_wb, ra_ld;
   logic rb_ex, rb_mem, rb_wb, rb_ld;

   assign ra_active = D_valid && D_use_ra && (D_ra != '0);
   assign rb_active = D_valid && D_use_rb && (D_rb != '0);

   operand_match u_match_ra (
      .active      (ra_active),
      .src         (ADDR_SIZE_DEFAULT'(D_ra)),
      .ex_slot     (ex_q),
      .mem_slot    (mem_q),
      .wb_slot     (wb_q),
      .ex_hit_c    (ra_ex),
      .mem_hit_c   (ra_mem),
      .wb_hit_c    (ra_wb),
      .ld_hazard_c (ra_ld)
   );

   operand_match u_match_rb (
      .active      (rb_active),
      .src         (ADDR_SIZE_DEFAULT'(D_rb)),
      .ex_slot     (ex_q),
      .mem_slot    (mem_q),
      .wb_slot     (wb_q),
      .ex_hit_c    (rb_ex),
      .mem_hit_c   (rb_mem),
      .wb_hit_c    (rb_wb),
      .ld_hazard_c (rb_ld)
   );

   // Decode-cycle outputs are combinational from the shadow slots.
   always_comb begin
      EX_D_bp         = '0;
      MEM_D_bp        = '0;
      WB_D_bp         = '0;
      EX_D_bp[BP_RA]  = ra_ex;
      EX_D_bp[BP_RB]  = rb_ex;
      MEM_D_bp[BP_RA] = ra_mem;
      MEM_D_bp[BP_RB] = rb_mem;
      WB_D_bp[BP_RA]  = ra_wb;
      WB_D_bp[BP_RB]  = rb_wb;
      D_stall         = ra_ld || rb_ld;
   end

   // Back end never stalls; a stalled or flushed decode becomes an EX bubble.
   always_comb begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = SLOT_BUBBLE;
      if (D_valid && !D_stall && !D_flush) begin
         ex_d.valid = 1'b1;
         ex_d.rd    = ADDR_SIZE_DEFAULT'(D_rd);
         ex_d.we    = D_we;
         ex_d.ld    = D_ld;
      end
      stall_cnt_d = stall_cnt_q;
      if (D_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= SLOT_BUBBLE;
         mem_q       <= SLOT_BUBBLE;
         wb_q        <= SLOT_BUBBLE;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
